// File: rtl/pci_pkg.sv
// pci_pkg: shared definitions for the PCI target sequencer and its address decoder.
//   CMD_MEM_RD / CMD_MEM_WR : accepted bus commands (C/BE# during address phase)
//   STORAGE_WORDS           : number of words in the storage array behind this target
//   state_e                 : target sequencer states
package pci_pkg;

  localparam logic [3:0]  CMD_MEM_RD    = 4'b0110;
  localparam logic [3:0]  CMD_MEM_WR    = 4'b0111;
  localparam int unsigned STORAGE_WORDS = 3;
  localparam int unsigned COUNT_W       = 3;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StTurn,
    StData,
    StWait,
    StDone
  } state_e;

  function automatic logic is_valid_cmd(input logic [3:0] cmd);
    return (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR);
  endfunction

endpackage

// File: rtl/pci_target_ctrl_if.sv
// pci_target_ctrl_if: PCI pin and storage-side signals of the target sequencer.
//   PCI in   : frame_n, irdy_n, ad[31:0], cbe_n[3:0]
//   PCI out  : devsel_n, trdy_n, stop_n, ad_oe
//   Storage  : st_busy_n (in), st_f, st_addr[1:0], st_re, st_we, st_be[3:0] (out)
// Modports: master = bus initiator + storage environment, slave = the target sequencer.
interface pci_target_ctrl_if;

  logic        frame_n;
  logic        irdy_n;
  logic [31:0] ad;
  logic [3:0]  cbe_n;
  logic        st_busy_n;
  logic        devsel_n;
  logic        trdy_n;
  logic        stop_n;
  logic        ad_oe;
  logic        st_f;
  logic [1:0]  st_addr;
  logic        st_re;
  logic        st_we;
  logic [3:0]  st_be;

  modport master (
    output frame_n, irdy_n, ad, cbe_n, st_busy_n,
    input  devsel_n, trdy_n, stop_n, ad_oe, st_f, st_addr, st_re, st_we, st_be
  );

  modport slave (
    input  frame_n, irdy_n, ad, cbe_n, st_busy_n,
    output devsel_n, trdy_n, stop_n, ad_oe, st_f, st_addr, st_re, st_we, st_be
  );

endinterface

// File: rtl/pci_addr_decode.sv
// pci_addr_decode: combinational address-phase decode.
//   i_ad_word[29:0] : AD[31:2] sampled during the address phase
//   o_hit           : address falls inside this target's window and names a real word
//   o_index[1:0]    : starting word index (AD[3:2])
module pci_addr_decode
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [29:0] i_ad_word,
  output logic        o_hit,
  output logic [1:0]  o_index
);

  logic w_base_match;
  logic w_word_valid;

  assign w_base_match = (i_ad_word[29:2] == BASE_ADDR[31:4]);
  // Only word indices that exist in storage are claimed (index 3 is a miss).
  assign w_word_valid = (32'(i_ad_word[1:0]) < STORAGE_WORDS);
  assign o_hit        = w_base_match && w_word_valid;
  assign o_index      = i_ad_word[1:0];

endmodule

// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl: PCI target sequencer in front of the three-word storage array.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : pci_target_ctrl_if.slave (PCI control lines in, DEVSEL#/TRDY#/STOP# out,
//              storage strobes out, storage ready in)
// Decodes memory read/write address phases, answers with medium DEVSEL#, inserts a
// turnaround cycle for reads, stalls on storage busy and disconnects after MAX_BURST
// data phases.
module pci_target_ctrl
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_BURST = 6
) (
  input logic             clk,
  input logic             rst,
  pci_target_ctrl_if.slave bus
);

  localparam logic [COUNT_W-1:0] LastCount = COUNT_W'(MAX_BURST - 1);
  localparam logic [COUNT_W-1:0] CountMax  = '1;

  state_e             r_state, w_state_d;
  logic               r_frame_prev;
  logic               r_write, w_write_d;
  logic [1:0]         r_index, w_index_d;
  logic [COUNT_W-1:0] r_count, w_count_d;
  logic               r_disc, w_disc_d;

  logic r_devsel_n, w_devsel_n_d;
  logic r_trdy_n, w_trdy_n_d;
  logic r_stop_n, w_stop_n_d;
  logic r_ad_oe, w_ad_oe_d;
  logic r_st_f, w_st_f_d;

  logic       w_hit;
  logic [1:0] w_dec_index;
  logic       w_addr_phase;
  logic       w_xfer;
  logic       w_claim;

  pci_addr_decode #(
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_decode (
    .i_ad_word (bus.ad[31:2]),
    .o_hit     (w_hit),
    .o_index   (w_dec_index)
  );

  // Address phase is the first edge with FRAME# low; r_frame_prev resets low so a FRAME#
  // already asserted when reset is released is never mistaken for a new address phase.
  assign w_addr_phase = !bus.frame_n && r_frame_prev;
  assign w_claim      = w_addr_phase && w_hit && is_valid_cmd(bus.cbe_n);
  assign w_xfer       = (r_state == StData) && !r_trdy_n && !bus.irdy_n;

  always_comb begin
    w_state_d = r_state;
    w_write_d = r_write;
    w_index_d = r_index;
    w_count_d = r_count;
    w_disc_d  = r_disc;

    unique case (r_state)
      StIdle: begin
        w_count_d = '0;
        w_disc_d  = 1'b0;
        if (w_claim) begin
          w_state_d = StDecode;
          w_write_d = (bus.cbe_n == CMD_MEM_WR);
          w_index_d = w_dec_index;
        end
      end
      StDecode: w_state_d = r_write ? StData : StTurn;
      StTurn:   w_state_d = StData;
      StData: begin
        if (r_disc) begin
          // Disconnect without data: hold STOP# until the master drops FRAME#.
          if (bus.frame_n) w_state_d = StDone;
        end else if (w_xfer) begin
          w_count_d = (r_count == CountMax) ? r_count : r_count + 1'b1;
          // A completing last phase wins over a storage stall.
          if (bus.frame_n) begin
            w_state_d = StDone;
          end else if (r_count == LastCount) begin
            w_disc_d = 1'b1;
          end else if (!bus.st_busy_n) begin
            w_state_d = StWait;
          end
        end else if (bus.frame_n && bus.irdy_n) begin
          w_state_d = StDone;
        end else if (!bus.st_busy_n) begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (bus.frame_n && bus.irdy_n) begin
          w_state_d = StDone;
        end else if (bus.st_busy_n) begin
          w_state_d = StData;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Pin outputs are decoded from the next state so they leave flops directly.
  always_comb begin
    w_devsel_n_d = 1'b1;
    w_st_f_d     = 1'b1;
    w_trdy_n_d   = 1'b1;
    w_stop_n_d   = 1'b1;
    w_ad_oe_d    = 1'b0;
    if ((w_state_d == StDecode) || (w_state_d == StTurn) ||
        (w_state_d == StData) || (w_state_d == StWait)) begin
      w_devsel_n_d = 1'b0;
      w_st_f_d     = 1'b0;
    end
    if (w_state_d == StData) begin
      w_trdy_n_d = w_disc_d;
      w_stop_n_d = !w_disc_d;
    end
    if (!w_write_d && ((w_state_d == StTurn) || (w_state_d == StData) ||
                       (w_state_d == StWait))) begin
      w_ad_oe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_frame_prev <= 1'b0;
      r_write      <= 1'b0;
      r_index      <= 2'd0;
      r_count      <= '0;
      r_disc       <= 1'b0;
      r_devsel_n   <= 1'b1;
      r_trdy_n     <= 1'b1;
      r_stop_n     <= 1'b1;
      r_ad_oe      <= 1'b0;
      r_st_f       <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_frame_prev <= bus.frame_n;
      r_write      <= w_write_d;
      r_index      <= w_index_d;
      r_count      <= w_count_d;
      r_disc       <= w_disc_d;
      r_devsel_n   <= w_devsel_n_d;
      r_trdy_n     <= w_trdy_n_d;
      r_stop_n     <= w_stop_n_d;
      r_ad_oe      <= w_ad_oe_d;
      r_st_f       <= w_st_f_d;
    end
  end

  assign bus.devsel_n = r_devsel_n;
  assign bus.trdy_n   = r_trdy_n;
  assign bus.stop_n   = r_stop_n;
  assign bus.ad_oe    = r_ad_oe;
  assign bus.st_f     = r_st_f;
  assign bus.st_addr  = r_index;

  // Strobes qualify the registered TRDY# with this cycle's IRDY# so storage captures on
  // the same edge the PCI data phase completes.
  assign bus.st_we = w_xfer && r_write;
  assign bus.st_re = w_xfer && !r_write;
  assign bus.st_be = w_xfer ? ~bus.cbe_n : 4'b0000;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// tb_pci_target_ctrl: directed table-driven bench for pci_target_ctrl.
// Each row gives the inputs held for one clock cycle and the outputs expected in that
// cycle; expected vector = {devsel_n, trdy_n, stop_n, ad_oe, st_f, st_addr, st_re, st_we, st_be}.
module tb_pci_target_ctrl;

  logic clk;
  logic rst;

  pci_target_ctrl_if bus_if ();

  pci_target_ctrl #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_BURST (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        frame_n;
    logic        irdy_n;
    logic [31:0] ad;
    logic [3:0]  cbe_n;
    logic        busy_n;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_errors;
  int   we_pulses;

  function automatic logic [12:0] e(input logic dv, input logic tr, input logic sp,
                                    input logic oe, input logic f, input logic [1:0] a,
                                    input logic re, input logic we, input logic [3:0] be);
    return {dv, tr, sp, oe, f, a, re, we, be};
  endfunction

  function automatic logic [12:0] idle(input logic [1:0] a);
    return e(1, 1, 1, 0, 1, a, 0, 0, 4'h0);
  endfunction

  function automatic logic [12:0] got();
    return {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.st_f,
            bus_if.st_addr, bus_if.st_re, bus_if.st_we, bus_if.st_be};
  endfunction

  task automatic add(input string n, input logic f, input logic i, input logic [31:0] a,
                     input logic [3:0] c, input logic b, input logic [12:0] x);
    vec_t v;
    v.name = n; v.frame_n = f; v.irdy_n = i; v.ad = a; v.cbe_n = c; v.busy_n = b; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [12:0] x);
    logic [12:0] g;
    g = got();
    n_checks++;
    if (g !== x) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", n, g, x);
    end
  endtask

  task automatic drive(input logic f, input logic i, input logic [31:0] a,
                       input logic [3:0] c, input logic b);
    bus_if.frame_n   = f;
    bus_if.irdy_n    = i;
    bus_if.ad        = a;
    bus_if.cbe_n     = c;
    bus_if.st_busy_n = b;
  endtask

  task automatic step(input string n, input logic f, input logic i, input logic [31:0] a,
                      input logic [3:0] c, input logic b, input logic [12:0] x);
    @(negedge clk);
    drive(f, i, a, c, b);
    #1;
    check(n, x);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    we_pulses = 0;
    rst = 1'b1;
    drive(1, 1, 32'h0, 4'hF, 1);

    // Write burst, word 0, three zero-wait phases.
    add("wr_idle",   1, 1, 32'h0, 4'hF, 1, idle(0));
    add("wr_addr",   0, 1, 32'h0, 4'h7, 1, idle(0));
    add("wr_devsel", 0, 0, 32'h0, 4'h0, 1, e(0, 1, 1, 0, 0, 0, 0, 0, 4'h0));
    add("wr_d1",     0, 0, 32'h0, 4'h0, 1, e(0, 0, 1, 0, 0, 0, 0, 1, 4'hF));
    add("wr_d2",     0, 0, 32'h0, 4'h0, 1, e(0, 0, 1, 0, 0, 0, 0, 1, 4'hF));
    add("wr_d3",     1, 0, 32'h0, 4'h0, 1, e(0, 0, 1, 0, 0, 0, 0, 1, 4'hF));
    add("wr_done",   1, 1, 32'h0, 4'hF, 1, idle(0));
    // Read from word 1 with turnaround and mixed byte enables.
    add("rd_idle",   1, 1, 32'h0, 4'hF, 1, idle(0));
    add("rd_addr",   0, 1, 32'h4, 4'h6, 1, idle(0));
    add("rd_devsel", 0, 0, 32'h0, 4'hA, 1, e(0, 1, 1, 0, 0, 1, 0, 0, 4'h0));
    add("rd_turn",   0, 0, 32'h0, 4'hA, 1, e(0, 1, 1, 1, 0, 1, 0, 0, 4'h0));
    add("rd_d1",     0, 0, 32'h0, 4'hA, 1, e(0, 0, 1, 1, 0, 1, 1, 0, 4'h5));
    add("rd_d2",     1, 0, 32'h0, 4'h3, 1, e(0, 0, 1, 1, 0, 1, 1, 0, 4'hC));
    add("rd_done",   1, 1, 32'h0, 4'hF, 1, idle(1));
    // Write to word 2 with a storage stall, a master wait and busy on the last phase.
    add("bz_idle",   1, 1, 32'h0, 4'hF, 1, idle(1));
    add("bz_addr",   0, 1, 32'h8, 4'h7, 1, idle(1));
    add("bz_devsel", 0, 0, 32'h0, 4'h0, 1, e(0, 1, 1, 0, 0, 2, 0, 0, 4'h0));
    add("bz_d1",     0, 0, 32'h0, 4'h0, 0, e(0, 0, 1, 0, 0, 2, 0, 1, 4'hF));
    add("bz_wait",   0, 0, 32'h0, 4'h0, 1, e(0, 1, 1, 0, 0, 2, 0, 0, 4'h0));
    add("bz_mwait",  0, 1, 32'h0, 4'h0, 1, e(0, 0, 1, 0, 0, 2, 0, 0, 4'h0));
    add("bz_d2",     0, 0, 32'h0, 4'h0, 1, e(0, 0, 1, 0, 0, 2, 0, 1, 4'hF));
    add("bz_d3",     1, 0, 32'h0, 4'h0, 0, e(0, 0, 1, 0, 0, 2, 0, 1, 4'hF));
    add("bz_done",   1, 1, 32'h0, 4'hF, 1, idle(2));
    // Misses: word 3, bad command, address outside the window.
    add("ms_idle",   1, 1, 32'h0, 4'hF, 1, idle(2));
    add("ms_w3",     0, 1, 32'hC, 4'h7, 1, idle(2));
    add("ms_w3_d",   0, 0, 32'h0, 4'h0, 1, idle(2));
    add("ms_idle2",  1, 1, 32'h0, 4'hF, 1, idle(2));
    add("ms_cmd",    0, 1, 32'h0, 4'h2, 1, idle(2));
    add("ms_cmd_d",  0, 0, 32'h0, 4'h0, 1, idle(2));
    add("ms_idle3",  1, 1, 32'h0, 4'hF, 1, idle(2));
    add("ms_base",   0, 1, 32'h10, 4'h6, 1, idle(2));
    add("ms_base_d", 0, 0, 32'h0, 4'h0, 1, idle(2));
    add("ms_idle4",  1, 1, 32'h0, 4'hF, 1, idle(2));

    @(negedge clk);
    #1;
    check("reset_state", idle(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].name, vecs[k].frame_n, vecs[k].irdy_n, vecs[k].ad, vecs[k].cbe_n,
           vecs[k].busy_n, vecs[k].exp);
    end

    // Disconnect: master offers eight phases, target takes six then asserts STOP#.
    step("dc_idle",   1, 1, 32'h0, 4'hF, 1, idle(2));
    step("dc_addr",   0, 1, 32'h0, 4'h7, 1, idle(2));
    step("dc_devsel", 0, 0, 32'h0, 4'h0, 1, e(0, 1, 1, 0, 0, 0, 0, 0, 4'h0));
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 4'h0, 1);
      #1;
      if (bus_if.st_we) we_pulses++;
      if (p < 6) check($sformatf("dc_phase%0d", p), e(0, 0, 1, 0, 0, 0, 0, 1, 4'hF));
      else       check($sformatf("dc_stop%0d", p), e(0, 1, 0, 0, 0, 0, 0, 0, 4'h0));
    end
    step("dc_release", 1, 1, 32'h0, 4'hF, 1, e(0, 1, 0, 0, 0, 0, 0, 0, 4'h0));
    step("dc_done",    1, 1, 32'h0, 4'hF, 1, idle(0));
    n_checks++;
    if (we_pulses != 6) begin
      n_errors++;
      $display("FAIL dc_pulses: got %0d required 6", we_pulses);
    end

    // Asynchronous reset in the middle of a write burst to word 2.
    step("rs_idle",   1, 1, 32'h0, 4'hF, 1, idle(0));
    step("rs_addr",   0, 1, 32'h8, 4'h7, 1, idle(0));
    step("rs_devsel", 0, 0, 32'h0, 4'h0, 1, e(0, 1, 1, 0, 0, 2, 0, 0, 4'h0));
    step("rs_d1",     0, 0, 32'h0, 4'h0, 1, e(0, 0, 1, 0, 0, 2, 0, 1, 4'hF));
    #1;
    rst = 1'b1;
    #1;
    check("rs_async", idle(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rs_held", idle(0));
    // FRAME# still low after reset must not be taken as an address phase.
    step("rs_frame_low", 0, 0, 32'h4, 4'h7, 1, idle(0));
    step("rs_no_claim",  0, 0, 32'h4, 4'h7, 1, idle(0));
    step("rs_idle2",     1, 1, 32'h0, 4'hF, 1, idle(0));
    step("rs_addr2",     0, 1, 32'h4, 4'h7, 1, idle(0));
    step("rs_devsel2",   1, 0, 32'h0, 4'h0, 1, e(0, 1, 1, 0, 0, 1, 0, 0, 4'h0));
    step("rs_d_last",    1, 0, 32'h0, 4'h9, 1, e(0, 0, 1, 0, 0, 1, 0, 1, 4'h6));
    step("rs_done",      1, 1, 32'h0, 4'hF, 1, idle(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pci_target_ctrl.md
# pci_target_ctrl

Target-side sequencer for the PCI slave. Watches the PCI control lines (frame_n, irdy_n, C/BE#, AD address phase), decodes command and address, and drives the DEVSEL#/TRDY#/STOP# handshake. It translates each accepted data phase into strobes for the three-word storage array and its six-entry buffer. It sits between the PCI pins and the storage block, and is the only block that sequences storage.

## Interface
- BASE_ADDR, 32'h0000_0000, decode base; hit when ad[31:4] == BASE_ADDR[31:4] and ad[3:2] != 2'b11
- MAX_BURST, 6, data phases accepted before target disconnect (1..7)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- frame_n  in  1  PCI FRAME#, active low
- irdy_n  in  1  PCI IRDY#, active low
- ad  in  32  AD bus as sampled (address phase only used)
- cbe_n  in  4  C/BE#: command in address phase, byte enables (active low) in data phases
- st_busy_n  in  1  storage ready; 0 = storage flushing to buffer this cycle
- devsel_n  out  1  PCI DEVSEL#
- trdy_n  out  1  PCI TRDY#
- stop_n  out  1  PCI STOP#
- ad_oe  out  1  storage drives AD (read data phases incl. turnaround)
- st_f  out  1  frame to storage, 1 = idle/no transaction
- st_addr  out  2  starting word index to storage
- st_re  out  1  storage read enable
- st_we  out  1  storage write enable
- st_be  out  4  byte enables to storage, active high (= ~cbe_n)

## Operation
- Commands: 4'b0110 memory read, 4'b0111 memory write; all others and address misses ignored (stay IDLE, no DEVSEL#).
- States: IDLE, DECODE, TURN, DATA, WAIT, DONE.
- IDLE: address phase = frame_n low this edge, high previous edge; latch ad[3:2], cbe_n, hit -> DECODE if hit and valid command, else remain IDLE until frame_n high.
- DECODE: assert devsel_n=0, st_f=0, st_addr=latched index; write -> DATA, read -> TURN.
- TURN: read turnaround, ad_oe=1, trdy_n=1; -> DATA.
- DATA: trdy_n=0; transfer = !irdy_n && !trdy_n. On transfer: st_we (write) or st_re (read) high that cycle, st_be=~cbe_n, burst count +1.
- Storage word index wraps 2->0 inside storage; controller only supplies start index.
- st_busy_n=0 in DATA -> WAIT: trdy_n=1, no strobes; return to DATA on first cycle st_busy_n=1.
- Last phase: transfer with frame_n high -> DONE.
- Burst count reaching MAX_BURST-1 on transfer while frame_n low: next cycle stop_n=0 with trdy_n=1 (disconnect without data); hold until frame_n high, then DONE.
- DONE: one cycle, devsel_n/trdy_n/stop_n=1, ad_oe=0, st_f=1, strobes 0; -> IDLE.
- frame_n and irdy_n both high in DATA/WAIT (master gave up): -> DONE.

## Timing
- Reset values: devsel_n=1, trdy_n=1, stop_n=1, ad_oe=0, st_f=1, st_addr=0, st_re=0, st_we=0, st_be=0, state IDLE, count 0.
- Reset mid-transaction: all outputs return to reset values immediately (async); next address phase requires frame_n high first.
- All outputs registered; DEVSEL# one cycle after address phase (medium decode).
- Write: first TRDY# one cycle after DEVSEL#. Read: two cycles after DEVSEL# (TURN).
- Zero-wait burst: one transfer per clock while irdy_n=0 and st_busy_n=1.
- irdy_n high in DATA: master wait, trdy_n stays 0, no strobe, count unchanged.
- Simultaneous st_busy_n=0 and last transfer: transfer completes, go DONE (busy ignored).
- Count width 3 bits, saturates; cleared in IDLE.

## Structure
- Shared package pci_pkg: command codes CMD_MEM_RD/CMD_MEM_WR, state enum type, STORAGE_WORDS=3.
- Single module, no sub-module; optional decode helper pci_addr_decode (combinational hit/index) is natural if reused by other targets.

## Test plan
- Write burst: ad=0x0, cbe_n=0111, data phases cbe_n=0000 x3 -> devsel_n low 1 cycle after addr, st_we pulses 3 cycles, st_be=1111, DONE then IDLE.
- Read with turnaround: cbe_n=0110, ad=0x4 -> st_addr=1, ad_oe high at TURN, trdy_n low 2 cycles after devsel_n, st_re per transfer.
- Storage busy: st_busy_n=0 for 1 cycle mid-write -> trdy_n high that cycle, no st_we, resumes next cycle, no data lost.
- Disconnect: 8-phase write with MAX_BURST=6 -> 6 st_we pulses, then stop_n=0, trdy_n=1 until frame_n high.
- Miss/bad command: ad=0x0C or cbe_n=0010 -> devsel_n stays 1, all strobes 0.
- Reset mid-burst: rst=1 during DATA -> outputs at reset values same cycle, next transaction decoded normally.
